alu_dispatch: RTL

- Operand-producing end of the ALU interface.
- Accepts a fetched RV32I instruction plus its register-file read data and PC over a valid/ready handshake.
- Decodes the instruction into the ALU select code and the two operands, and holds them in a pipeline register that drives the ALU inputs and the writeback/branch controls.
- Sits between decode/register-read and execute. Gives one instruction per cycle of throughput with backpressure.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_decode.sv | 109 ++++++++++
 rtl/alu_dispatch.sv | 115 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatch slice: opcodes, ALU select
// codes and the registered dispatch payload.
package alu_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SLL  = 4'h1,
        ALU_SLT  = 4'h2,
        ALU_SLTU = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SRL  = 4'h5,
        ALU_OR   = 4'h6,
        ALU_AND  = 4'h7,
        ALU_SUB  = 4'h8,
        ALU_SRA  = 4'hD
    } alu_sel_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        alu_sel_e    sel;
        logic [4:0]  rd;
        logic        we;
        logic        branch;
        logic        br_inv;
        logic [31:0] store_data;
        logic [31:0] pc;
        logic        illegal;
    } dispatch_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode: instruction, pc and register data in,
// ALU operands, select code and writeback/branch controls out.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output dispatch_t   d_o
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;

    assign opc   = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign rd    = instr_i[11:7];
    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_u = {instr_i[31:12], 12'h000};

    logic wr;
    logic ill;

    // Per-opcode operand/select selection, then illegal squashing
    always_comb begin
        d_o            = '0;
        d_o.a          = rs1_i;
        d_o.b          = rs2_i;
        d_o.sel        = ALU_ADD;
        d_o.rd         = rd;
        d_o.store_data = rs2_i;
        d_o.pc         = pc_i;
        wr             = 1'b0;
        ill            = 1'b0;
        case (opc)
            OPC_OP: begin
                wr      = 1'b1;
                d_o.sel = alu_sel_e'({instr_i[30], f3});
                if (f7 != 7'h00 && f7 != 7'h20)
                    ill = 1'b1;
                if (instr_i[30] && f3 != 3'd0 && f3 != 3'd5)
                    ill = 1'b1;
            end
            OPC_OP_IMM: begin
                wr = 1'b1;
                d_o.sel = alu_sel_e'({(f3 == 3'd5) & instr_i[30], f3});
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    d_o.b = {27'd0, instr_i[24:20]};
                    if ((f7 & 7'b1011111) != 7'd0)
                        ill = 1'b1;
                end else begin
                    d_o.b = imm_i;
                end
            end
            OPC_LOAD: begin
                wr    = 1'b1;
                d_o.b = imm_i;
            end
            OPC_STORE: begin
                d_o.b = imm_s;
            end
            OPC_LUI: begin
                wr    = 1'b1;
                d_o.a = '0;
                d_o.b = imm_u;
            end
            OPC_AUIPC: begin
                wr    = 1'b1;
                d_o.a = pc_i;
                d_o.b = imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                // Link value pc+4; the jump target is formed elsewhere
                wr    = 1'b1;
                d_o.a = pc_i;
                d_o.b = 32'd4;
            end
            OPC_BRANCH: begin
                d_o.branch = 1'b1;
                case (f3)
                    3'd0: begin d_o.sel = ALU_SUB;  d_o.br_inv = 1'b0; end
                    3'd1: begin d_o.sel = ALU_SUB;  d_o.br_inv = 1'b1; end
                    3'd4: begin d_o.sel = ALU_SLT;  d_o.br_inv = 1'b1; end
                    3'd5: begin d_o.sel = ALU_SLT;  d_o.br_inv = 1'b0; end
                    3'd6: begin d_o.sel = ALU_SLTU; d_o.br_inv = 1'b1; end
                    3'd7: begin d_o.sel = ALU_SLTU; d_o.br_inv = 1'b0; end
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            d_o.sel    = ALU_ADD;
            d_o.branch = 1'b0;
            d_o.br_inv = 1'b0;
        end
        d_o.illegal = ill;
        d_o.we      = wr & ~ill & (rd != 5'd0);
    end

endmodule

// File: rtl/alu_dispatch.sv
// Valid/ready pipeline register feeding the ALU from decoded RV32I.
// Optional input skid buffer enabled by defining ALU_DISPATCH_SKID_EN.
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [3:0]      out_sel,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_branch,
    output logic            out_br_inv,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    dispatch_t dec_d;
    dispatch_t pay_q;
    logic      valid_q;
    logic      load_out;
    dispatch_t pay_rst;

    alu_decode u_decode (
        .instr_i (in_instr),
        .pc_i    (in_pc),
        .rs1_i   (in_rs1_data),
        .rs2_i   (in_rs2_data),
        .d_o     (dec_d)
    );

    // Reset payload: everything zero except the pc
    always_comb begin
        pay_rst    = '0;
        pay_rst.pc = RESET_PC;
    end

    assign load_out = !valid_q || out_ready;

`ifdef ALU_DISPATCH_SKID_EN
    dispatch_t skid_q;
    logic      skid_full_q;

    assign in_ready = !skid_full_q;

    // Output register refills from the skid first; stalled arrivals park
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pay_q       <= pay_rst;
            skid_q      <= pay_rst;
            skid_full_q <= 1'b0;
        end else if (flush) begin
            valid_q     <= 1'b0;
            skid_full_q <= 1'b0;
        end else if (load_out) begin
            if (skid_full_q) begin
                pay_q       <= skid_q;
                valid_q     <= 1'b1;
                skid_full_q <= 1'b0;
            end else begin
                valid_q <= in_valid;
                if (in_valid)
                    pay_q <= dec_d;
            end
        end else if (in_valid && !skid_full_q) begin
            skid_q      <= dec_d;
            skid_full_q <= 1'b1;
        end
    end
`else
    assign in_ready = flush || load_out;

    // Single pipeline register; flush drops held and arriving work
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pay_q   <= pay_rst;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load_out) begin
            valid_q <= in_valid;
            if (in_valid)
                pay_q <= dec_d;
        end
    end
`endif

    assign out_valid      = valid_q;
    assign out_a          = pay_q.a;
    assign out_b          = pay_q.b;
    assign out_sel        = pay_q.sel;
    assign out_rd         = pay_q.rd;
    assign out_we         = pay_q.we;
    assign out_branch     = pay_q.branch;
    assign out_br_inv     = pay_q.br_inv;
    assign out_store_data = pay_q.store_data;
    assign out_pc         = pay_q.pc;
    assign out_illegal    = pay_q.illegal;

endmodule
